cmp_swap_stage: RTL

CMP_SWAP_STAGE -- requirements
Module: cmp_swap_stage

---
 rtl/cmp_swap_pkg.sv | 24 ++
 rtl/skid_buf.sv | 64 ++++++
 rtl/cmp_swap_stage.sv | 75 +++++++
 3 files changed

// File: rtl/cmp_swap_pkg.sv
// Shared definitions for the compare/swap pipeline stage: operation encodings
// and the width-independent exchange decision.
package cmp_swap_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_PASS      = 2'd0;
   localparam mode_t MODE_SWAP      = 2'd1;
   localparam mode_t MODE_SORT_ASC  = 2'd2;
   localparam mode_t MODE_SORT_DESC = 2'd3;

   // Equal operands give a_gt_b == a_lt_b == 0, so sort modes never exchange them.
   function automatic logic swap_decision(input mode_t mode,
                                          input logic  a_gt_b,
                                          input logic  a_lt_b);
      case (mode)
         MODE_PASS:     return 1'b0;
         MODE_SWAP:     return 1'b1;
         MODE_SORT_ASC: return a_gt_b;
         default:       return a_lt_b;
      endcase
   endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry output stage: an output register plus one skid register, giving
// full throughput with in_ready driven straight from a flop.
module skid_buf #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         skid_valid;
   logic [W-1:0] skid_data;
   logic         in_xfer;
   logic         out_xfer;

   assign in_ready = !skid_valid;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         out_data   <= '0;
      end else if (out_xfer) begin
         if (skid_valid) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
         end else if (in_xfer) begin
            out_data <= in_data;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (in_xfer) begin
         if (out_valid) begin
            skid_valid <= 1'b1;
         end else begin
            out_valid <= 1'b1;
            out_data  <= in_data;
         end
      end
   end

   // NOTE: skid_data is payload only and is never observed unless skid_valid
   // is set, so it carries no reset and stays a plain enable flop.
   always_ff @(posedge clk) begin
      if (in_xfer && out_valid && !out_xfer)
         skid_data <= in_data;
   end

   a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
      out_valid && !out_ready |=> out_valid && $stable(out_data));

   a_skid_implies_out: assert property (@(posedge clk) disable iff (!reset_n)
      skid_valid |-> out_valid);

endmodule

// File: rtl/cmp_swap_stage.sv
// Compare/exchange stage: decides per pair whether to exchange operands, then
// registers the result through a skid buffer and counts exchanged pairs.
module cmp_swap_stage
   import cmp_swap_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_swapped,
   input  logic             clear_count,
   output logic [CNT_W-1:0] swap_count
);

   localparam int PW = 2 * WIDTH + 1;

   logic             exch;
   logic [WIDTH-1:0] res_a;
   logic [WIDTH-1:0] res_b;
   logic [PW-1:0]    in_payload;
   logic [PW-1:0]    out_payload;
   logic             in_xfer;

   assign exch = swap_decision(mode_t'(in_mode), in_a > in_b, in_a < in_b);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch
      // is inferred.
      res_a = in_a;
      res_b = in_b;
      if (exch) begin
         res_a = in_b;
         res_b = in_a;
      end
   end

   assign in_payload = {exch, res_a, res_b};

   skid_buf #(
      .W (PW)
   ) u_skid_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_payload),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_payload)
   );

   assign {out_swapped, out_a, out_b} = out_payload;
   assign in_xfer = in_valid && in_ready;

   // Clear wins over a same-edge increment; the count holds at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         swap_count <= '0;
      else if (clear_count)
         swap_count <= '0;
      else if (in_xfer && exch && (swap_count != {CNT_W{1'b1}}))
         swap_count <= swap_count + 1'b1;
   end

endmodule
